// File: rtl/uart_io_ctrl.sv
// UART boot loader and runtime byte arbiter: loads a length-prefixed program into imem,
// sends an ACK byte, then releases the core and serves its in/out requests through FIFOs.
module uart_io_ctrl #(
  parameter int          RX_DEPTH_LOG = 4,
  parameter int          TX_DEPTH_LOG = 4,
  parameter int          IMEM_ADDR_W  = 14,
  parameter logic [7:0]  ACK_BYTE     = 8'hAA
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   cpu_run,
  input  logic                   cpu_in_req,
  output logic                   cpu_in_ack,
  output logic [7:0]             cpu_in_data,
  input  logic                   cpu_out_req,
  input  logic [7:0]             cpu_out_data,
  output logic                   cpu_out_ack,
  output logic                   rx_err,
  output logic                   rx_ovf
);
  localparam int RXD = 1 << RX_DEPTH_LOG;
  localparam int TXD = 1 << TX_DEPTH_LOG;

  typedef enum logic [1:0] {S_LOAD_LEN, S_LOAD_WORD, S_ACK, S_RUN} state_t;
  state_t r_state, w_next;

  logic [1:0]             r_byte_cnt;
  logic [31:0]            r_shift, r_len, r_word_cnt;
  logic [IMEM_ADDR_W-1:0] r_waddr, r_imem_addr;
  logic [31:0]            r_imem_wdata;
  logic                   r_imem_we, r_cpu_run, r_rx_err, r_rx_ovf, r_tx_start;
  logic [7:0]             r_tx_data;

  logic [7:0]              r_rx_mem [RXD];
  logic [RX_DEPTH_LOG-1:0] r_rx_wp, r_rx_rp;
  logic [RX_DEPTH_LOG:0]   r_rx_cnt;
  logic [7:0]              r_tx_mem [TXD];
  logic [TX_DEPTH_LOG-1:0] r_tx_wp, r_tx_rp;
  logic [TX_DEPTH_LOG:0]   r_tx_cnt;

  logic        w_acc, w_word_done, w_last_word;
  logic [31:0] w_word;
  logic        w_assemble, w_len_done, w_wr, w_ack_go, w_run;
  logic        w_rx_full, w_rx_push, w_rx_drop, w_tx_full, w_tx_pop;

  assign w_acc       = rx_ready & ~rx_ferr;
  assign w_word      = {r_shift[23:0], rx_data};
  assign w_word_done = w_acc & (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt + 32'd1) == r_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_LOAD_LEN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD_LEN:  if (w_word_done) w_next = (w_word == 32'd0) ? S_ACK : S_LOAD_WORD;
      S_LOAD_WORD: if (w_word_done && w_last_word) w_next = S_ACK;
      S_ACK:       if (!tx_busy) w_next = S_RUN;
      default:     w_next = S_RUN;
    endcase
  end

  // Acks are qualified by the registered run flag so the core only sees them once released.
  always_comb begin
    w_run       = (r_state == S_RUN);
    w_assemble  = w_acc & ((r_state == S_LOAD_LEN) | (r_state == S_LOAD_WORD));
    w_len_done  = (r_state == S_LOAD_LEN) & w_word_done;
    w_wr        = (r_state == S_LOAD_WORD) & w_word_done;
    w_ack_go    = (r_state == S_ACK) & ~tx_busy;
    w_rx_full   = r_rx_cnt == (RX_DEPTH_LOG+1)'(RXD);
    w_tx_full   = r_tx_cnt == (TX_DEPTH_LOG+1)'(TXD);
    cpu_in_ack  = r_cpu_run & cpu_in_req & (r_rx_cnt != '0);
    cpu_out_ack = r_cpu_run & cpu_out_req & ~w_tx_full;
    w_rx_push   = w_run & w_acc & (~w_rx_full | cpu_in_ack);
    w_rx_drop   = w_run & w_acc & w_rx_full & ~cpu_in_ack;
    w_tx_pop    = (r_tx_cnt != '0) & ~tx_busy & ~r_tx_start;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_waddr      <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_run    <= 1'b0;
      r_rx_err     <= 1'b0;
      r_rx_ovf     <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_imem_we  <= 1'b0;
      r_tx_start <= 1'b0;
      r_cpu_run  <= w_run;
      if (rx_ready && rx_ferr) r_rx_err <= 1'b1;
      if (w_rx_drop)           r_rx_ovf <= 1'b1;
      if (w_assemble) begin
        r_shift    <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_len_done) begin
        r_len      <= w_word;
        r_word_cnt <= '0;
        r_waddr    <= '0;
      end
      if (w_wr) begin
        r_imem_we    <= 1'b1;
        r_imem_addr  <= r_waddr;
        r_imem_wdata <= w_word;
        r_waddr      <= r_waddr + IMEM_ADDR_W'(1);
        r_word_cnt   <= r_word_cnt + 32'd1;
      end
      if (w_ack_go) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= ACK_BYTE;
      end else if (w_tx_pop) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= r_tx_mem[r_tx_rp];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx_push)   r_rx_wp <= r_rx_wp + RX_DEPTH_LOG'(1);
      if (cpu_in_ack)  r_rx_rp <= r_rx_rp + RX_DEPTH_LOG'(1);
      case ({w_rx_push, cpu_in_ack})
        2'b10:   r_rx_cnt <= r_rx_cnt + (RX_DEPTH_LOG+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (RX_DEPTH_LOG+1)'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (cpu_out_ack) r_tx_wp <= r_tx_wp + TX_DEPTH_LOG'(1);
      if (w_tx_pop)    r_tx_rp <= r_tx_rp + TX_DEPTH_LOG'(1);
      case ({cpu_out_ack, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (TX_DEPTH_LOG+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (TX_DEPTH_LOG+1)'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push)   r_rx_mem[r_rx_wp] <= rx_data;
    if (cpu_out_ack) r_tx_mem[r_tx_wp] <= cpu_out_data;
  end

  assign cpu_in_data = r_rx_mem[r_rx_rp];
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign cpu_run     = r_cpu_run;
  assign rx_err      = r_rx_err;
  assign rx_ovf      = r_rx_ovf;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: expected imem writes, tx bytes and core input bytes are
// queued from a program/stream model and popped by a negedge monitor as the DUT presents them.
module tb_uart_io_ctrl;
  localparam int AW = 14;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rx_data = '0, tx_data, cpu_in_data, cpu_out_data = '0;
  logic          rx_ready = 1'b0, rx_ferr = 1'b0, tx_start, tx_busy;
  logic          imem_we, cpu_run, cpu_in_req = 1'b0, cpu_in_ack;
  logic          cpu_out_req = 1'b0, cpu_out_ack, rx_err, rx_ovf;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  uart_io_ctrl dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .cpu_in_req(cpu_in_req), .cpu_in_ack(cpu_in_ack), .cpu_in_data(cpu_in_data),
    .cpu_out_req(cpu_out_req), .cpu_out_data(cpu_out_data), .cpu_out_ack(cpu_out_ack),
    .rx_err(rx_err), .rx_ovf(rx_ovf)
  );

  // uart_tx stand-in: busy for a few cycles after each start, plus a manual hold-off
  logic       force_busy = 1'b0;
  logic [2:0] busy_cnt = '0;
  always @(posedge clk)
    if (tx_start)           busy_cnt <= 3'd3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 3'd1;
  assign tx_busy = force_busy | (busy_cnt != 0);

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_rx[$];
  logic [31:0] prog[$];
  int n_cmp = 0, n_err = 0, cyc = 0, last_tx = -10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    cyc++;
    if (rstn) begin
      if (imem_we) begin
        if (exp_wr.size() == 0) check("imem_we_unexpected", 1, 0);
        else begin
          e = exp_wr.pop_front();
          check("imem_addr", imem_addr, e.a);
          check("imem_wdata", imem_wdata, e.d);
        end
      end
      if (tx_start) begin
        check("tx_spacing", cyc - last_tx >= 2, 1);
        last_tx = cyc;
        if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (cpu_in_ack) begin
        if (exp_rx.size() == 0) check("in_ack_unexpected", 1, 0);
        else check("cpu_in_data", cpu_in_data, exp_rx.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(posedge clk); #1 rx_data = b; rx_ready = 1'b1; rx_ferr = fe;
    @(posedge clk); #1 rx_ready = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  // Model of a load: word i lands at address i mod 2^AW, then one ACK byte.
  task automatic load_prog();
    wr_t e;
    for (int i = 0; i < prog.size(); i++) begin
      e.a = AW'(i); e.d = prog[i]; exp_wr.push_back(e);
    end
    exp_tx.push_back(8'hAA);
    send_word(32'(prog.size()));
    for (int i = 0; i < prog.size(); i++) send_word(prog[i]);
  endtask

  task automatic wait_ack_run();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_start) break;
    end
    check("ack_start_seen", i < 100, 1);
    check("cpu_run_with_ack", cpu_run, 0);
    @(negedge clk);
    check("cpu_run_after_ack", cpu_run, 1);
  endtask

  task automatic do_reset(input string tag);
    #2 rstn = 1'b0; rx_ready = 1'b0; cpu_in_req = 1'b0; cpu_out_req = 1'b0;
    #2;
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_rx_err"}, rx_err, 0);
    check({tag, "_rx_ovf"}, rx_ovf, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic out_byte(input logic [7:0] d, input int bound, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1 cpu_out_req = 1'b1; cpu_out_data = d;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cpu_out_ack) begin ok = 1'b1; break; end
    end
    if (ok) exp_tx.push_back(d);
    @(posedge clk); #1 cpu_out_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && (exp_tx.size() != 0 || exp_rx.size() != 0 || exp_wr.size() != 0); i++)
      @(negedge clk);
    check(name, exp_tx.size() + exp_rx.size() + exp_wr.size(), 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nacc;
    logic [7:0] b;
    do_reset("rst0");

    // Abort mid-word: nothing must be written
    send_word(32'd1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    do_reset("rst_mid");

    // Two-word load with a framing error injected mid-word
    exp_wr.push_back('{a: AW'(0), d: 32'hDEADBEEF});
    exp_wr.push_back('{a: AW'(1), d: 32'h01234567});
    exp_tx.push_back(8'hAA);
    send_word(32'd2);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
    send_word(32'h01234567);
    wait_ack_run();
    check("rx_err_sticky", rx_err, 1);
    drain("load_drained");

    // RX overflow: 16 buffered, 17th dropped
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom); exp_rx.push_back(b); send_byte(b, 1'b0);
    end
    check("rx_ovf_at_16", rx_ovf, 0);
    send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    check("rx_ovf_at_17", rx_ovf, 1);
    @(posedge clk); #1 cpu_in_req = 1'b1;
    drain("rx_fifo_drained");
    repeat (4) @(posedge clk);
    // Streaming: each byte is consumed as it arrives
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom); exp_rx.push_back(b); send_byte(b, 1'b0);
    end
    drain("rx_stream_drained");
    #1 cpu_in_req = 1'b0;

    // TX backpressure
    force_busy = 1'b1;
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      out_byte(8'($urandom), 10, ok);
      if (ok) nacc++;
    end
    check("tx_accept16", nacc, 16);
    out_byte(8'($urandom), 6, ok);
    check("tx_full_stall", ok, 0);
    force_busy = 1'b0;
    out_byte(8'($urandom), 200, ok);
    check("tx_17th_acked", ok, 1);
    drain("tx_drained");

    // Empty program after reset
    do_reset("rst_run");
    exp_tx.push_back(8'hAA);
    send_word(32'd0);
    wait_ack_run();
    drain("empty_drained");

    // Random program, then a few core output bytes
    do_reset("rst_rand");
    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back($urandom);
    load_prog();
    wait_ack_run();
    for (int i = 0; i < 5; i++) out_byte(8'($urandom), 50, ok);
    drain("rand_drained");
    check("rx_err_clean", rx_err, 0);
    check("rx_ovf_clean", rx_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_io_ctrl.md
# uart_io_ctrl

Sequences the shared UART pair (uart_rx / uart_tx) between the boot loader and the running core. After reset it receives a length-prefixed program over UART, writes it word by word into instruction memory and acknowledges with a handshake byte. It then releases the core (`cpu_run`) and arbitrates UART traffic for the core's in/out instructions through an RX FIFO and a TX FIFO. It sits in `top` between the UART macros and the core/imem.

## Interface
- `RX_DEPTH_LOG`, 4: RX FIFO depth = 2^RX_DEPTH_LOG bytes
- `TX_DEPTH_LOG`, 4: TX FIFO depth = 2^TX_DEPTH_LOG bytes
- `IMEM_ADDR_W`, 14: instruction-memory word-address width
- `ACK_BYTE`, 8'hAA: byte sent when loading completes

- `clk` in 1: system clock; single clock domain
- `rstn` in 1: reset, asynchronous, active-low
- `rx_data` in 8: byte from uart_rx
- `rx_ready` in 1: one-cycle pulse; `rx_data` valid
- `rx_ferr` in 1: framing error, qualified by `rx_ready`
- `tx_data` out 8: byte to uart_tx
- `tx_start` out 1: one-cycle pulse; start transmit
- `tx_busy` in 1: uart_tx is transmitting
- `imem_we` out 1: imem write strobe
- `imem_addr` out IMEM_ADDR_W: imem word address
- `imem_wdata` out 32: imem write data
- `cpu_run` out 1: core may execute; 0 holds the core
- `cpu_in_req` in 1: core requests an input byte
- `cpu_in_ack` out 1: input byte delivered this cycle
- `cpu_in_data` out 8: input byte (RX FIFO head)
- `cpu_out_req` in 1: core requests an output byte
- `cpu_out_data` in 8: byte to output
- `cpu_out_ack` out 1: output byte accepted this cycle
- `rx_err` out 1: sticky; framing error seen
- `rx_ovf` out 1: sticky; RX byte dropped (FIFO full)

## Operation
- FSM states: LOAD_LEN → LOAD_WORD → ACK → RUN. Reset enters LOAD_LEN. RUN is left only by reset.
- Accepted byte: `rx_ready`=1 and `rx_ferr`=0. A byte with `rx_ferr`=1 is discarded in every state and sets `rx_err`.
- Byte assembly is big-endian: the first byte goes to [31:24]. A 2-bit byte counter clears on each completed word.
- LOAD_LEN: four bytes form the word count N. If N=0, go to ACK. Otherwise clear the word counter and address, then go to LOAD_WORD.
- LOAD_WORD: on each fourth byte, write the assembled word to `imem_addr`. The address then increments and wraps modulo 2^IMEM_ADDR_W; a wrapped address overwrites. After the Nth word, go to ACK.
- ACK: when `tx_busy`=0, pulse `tx_start` with `tx_data`=ACK_BYTE, then go to RUN. Bytes received in ACK are discarded.
- RUN: `cpu_run`=1. Accepted bytes are pushed to the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and `rx_ovf` is set.
  - A simultaneous pop and push on a full FIFO accepts the push; count is unchanged.
- Input path: `cpu_in_ack` = RUN & `cpu_in_req` & RX non-empty, combinational. The pop happens at that clock edge. `cpu_in_data` always shows the FIFO head. The core holds `cpu_in_req` until ack, so it stalls while the FIFO is empty.
- Output path: `cpu_out_ack` = RUN & `cpu_out_req` & TX not full, combinational. `cpu_out_data` is pushed at that edge.
- TX drain: pulse `tx_start` with the TX FIFO head, and pop, when the TX FIFO is non-empty, `tx_busy`=0 and `tx_start`=0 in the previous cycle. The one-cycle guard covers `tx_busy` lag.
- Outside RUN, both acks are 0 and the FIFOs are not written.

## Timing
- Reset values (async, all outputs): `tx_data`=0, `tx_start`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `rx_err`=0, `rx_ovf`=0; FIFOs empty.
- `imem_we`: one-cycle pulse in the cycle after the `rx_ready` of the word's 4th byte. `imem_addr` and `imem_wdata` are registered and stable during the pulse.
- ACK byte: `tx_start` is asserted no earlier than the cycle after the last `imem_we`. `cpu_run` rises in the cycle after the ACK `tx_start`.
- RX latency: a byte accepted at edge k is visible on `cpu_in_data` and can be acked in cycle k+1.
- TX latency: a byte pushed at edge k can be started with `tx_start` in cycle k+1 at the earliest. Consecutive `tx_start` pulses are at least 2 cycles apart.
- Reset mid-load or mid-run aborts immediately. A partial word is never written. An in-flight uart_tx frame is not this block's concern.

## Test plan
- Load: send 00 00 00 02, DE AD BE EF, 01 23 45 67 → `imem_we` at addr 0 with 32'hDEADBEEF, then addr 1 with 32'h01234567; one `tx_start` with 8'hAA; then `cpu_run`=1.
- Empty program: send 00 00 00 00 → no `imem_we`; AA sent; `cpu_run`=1.
- Framing error: during load, inject one byte with `rx_ferr`=1 mid-word → byte ignored, `rx_err`=1, the word assembles from the next valid byte.
- RX overflow: in RUN with `cpu_in_req`=0, send 17 bytes (RX_DEPTH_LOG=4) → 16 bytes buffered, 17th dropped, `rx_ovf`=1. Then raise `cpu_in_req` → acks return the first 16 bytes in order.
- TX backpressure: hold `tx_busy`=1 and issue 17 out requests → 16 acked, the 17th stalls. Release `tx_busy` → bytes go out in order, `tx_start` pulses ≥2 cycles apart, and the 17th is acked once a slot frees.
- Reset mid-load: assert `rstn`=0 after 2 bytes of the first program word → all outputs take reset values; a subsequent full load starts at addr 0.
